// File: rtl/reg_file_sb.sv
// reg_file_sb: byte-enabled register file with write bypass, busy scoreboard
// and a one-entry-per-cycle sequential clear engine.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic [ADDR_W-1:0]   R_Addr_A,
  input  logic [ADDR_W-1:0]   R_Addr_B,
  output logic [DATA_W-1:0]   R_Data_A,
  output logic [DATA_W-1:0]   R_Data_B,
  output logic                Busy_A,
  output logic                Busy_B,
  input  logic                Write_Reg,
  input  logic [ADDR_W-1:0]   W_Addr,
  input  logic [DATA_W-1:0]   W_Data,
  input  logic [DATA_W/8-1:0] W_Be,
  input  logic                Set_Busy,
  input  logic [ADDR_W-1:0]   Busy_Addr,
  input  logic                Clear,
  output logic                Ready
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic {IDLE, CLEARING} state_t;
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                busy_q [DEPTH];
  logic [DATA_W-1:0]   mask;
  logic                idle, wr_en, set_en, zero_a, zero_b, byp_a, byp_b;
  for (genvar k = 0; k < DATA_W / 8; k++) begin : g_mask
    assign mask[8*k +: 8] = {8{W_Be[k]}};
  end
  assign idle   = state_q == IDLE;
  assign Ready  = idle;
  assign zero_a = ZERO_REG != 0 && R_Addr_A == '0;
  assign zero_b = ZERO_REG != 0 && R_Addr_B == '0;
  assign wr_en  = Write_Reg && idle && !(ZERO_REG != 0 && W_Addr == '0);
  assign set_en = Set_Busy && idle && !(ZERO_REG != 0 && Busy_Addr == '0);
  assign byp_a  = BYPASS != 0 && wr_en && W_Addr == R_Addr_A;
  assign byp_b  = BYPASS != 0 && wr_en && W_Addr == R_Addr_B;
  assign R_Data_A = zero_a ? '0 : byp_a ? (W_Data & mask) | (mem_q[R_Addr_A] & ~mask) : mem_q[R_Addr_A];
  assign R_Data_B = zero_b ? '0 : byp_b ? (W_Data & mask) | (mem_q[R_Addr_B] & ~mask) : mem_q[R_Addr_B];
  assign Busy_A = !zero_a && !byp_a && busy_q[R_Addr_A];
  assign Busy_B = !zero_b && !byp_b && busy_q[R_Addr_B];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (idle && Clear) begin
      state_d = CLEARING;
      cnt_d   = '0;
    end else if (!idle) begin
      cnt_d   = cnt_q + 1'b1;
      state_d = &cnt_q ? IDLE : CLEARING;
    end
  end
  // Set is applied after the write-side clear so a same-address set wins.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i]  <= '0;
        busy_q[i] <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!idle) begin
        mem_q[cnt_q]  <= '0;
        busy_q[cnt_q] <= 1'b0;
      end else begin
        if (wr_en) mem_q[W_Addr] <= (W_Data & mask) | (mem_q[W_Addr] & ~mask);
        if (Write_Reg) busy_q[W_Addr] <= 1'b0;
        if (set_en) busy_q[Busy_Addr] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed checks of reg_file_sb; a second instance with
// ZERO_REG=0, BYPASS=0 shares the stimulus to cover the alternate variant.
module tb_reg_file_sb;
  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [4:0]  R_Addr_A, R_Addr_B, W_Addr, Busy_Addr;
  logic [31:0] R_Data_A, R_Data_B, nz_data_a, nz_data_b, W_Data;
  logic        Busy_A, Busy_B, nz_busy_a, nz_busy_b, nz_ready;
  logic        Write_Reg, Set_Busy, Clear, Ready;
  logic [3:0]  W_Be;
  int          checks = 0;
  int          failures = 0;
  int          n;

  always #5 Clk = ~Clk;

  reg_file_sb u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B),
    .R_Data_A(R_Data_A), .R_Data_B(R_Data_B), .Busy_A(Busy_A), .Busy_B(Busy_B),
    .Write_Reg(Write_Reg), .W_Addr(W_Addr), .W_Data(W_Data), .W_Be(W_Be),
    .Set_Busy(Set_Busy), .Busy_Addr(Busy_Addr), .Clear(Clear), .Ready(Ready)
  );

  reg_file_sb #(.ZERO_REG(0), .BYPASS(0)) u_nz (
    .Clk(Clk), .Reset_n(Reset_n), .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B),
    .R_Data_A(nz_data_a), .R_Data_B(nz_data_b), .Busy_A(nz_busy_a), .Busy_B(nz_busy_b),
    .Write_Reg(Write_Reg), .W_Addr(W_Addr), .W_Data(W_Data), .W_Be(W_Be),
    .Set_Busy(Set_Busy), .Busy_Addr(Busy_Addr), .Clear(Clear), .Ready(nz_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset_n = 1'b0; R_Addr_A = '0; R_Addr_B = '0; W_Addr = '0; Busy_Addr = '0;
    W_Data = '0; W_Be = '0; Write_Reg = 1'b0; Set_Busy = 1'b0; Clear = 1'b0;
    step(); step();
    Reset_n = 1'b1;
    // reset
    Write_Reg = 1'b1; W_Addr = 5'd5; W_Data = 32'hDEADBEEF; W_Be = 4'hF;
    step();
    Write_Reg = 1'b0; R_Addr_A = 5'd5; #1;
    chk("pre_reset_data", R_Data_A, 32'hDEADBEEF);
    Reset_n = 1'b0; #1;
    chk("reset_data", R_Data_A, 32'h0);
    chk("reset_busy", {31'b0, Busy_A}, 32'h0);
    chk("reset_ready", {31'b0, Ready}, 32'h1);
    step(); step();
    Reset_n = 1'b1;
    // byte-enable write with bypass
    Write_Reg = 1'b1; W_Addr = 5'd7; W_Data = 32'h11223344; W_Be = 4'hF;
    step();
    W_Data = 32'hAABBCCDD; W_Be = 4'b0101; R_Addr_B = 5'd7; #1;
    chk("bypass_data", R_Data_B, 32'h11BB33DD);
    chk("nobypass_data", nz_data_b, 32'h11223344);
    step();
    Write_Reg = 1'b0; #1;
    chk("byte_write", R_Data_B, 32'h11BB33DD);
    chk("byte_write_nz", nz_data_b, 32'h11BB33DD);
    // zero register
    Write_Reg = 1'b1; W_Addr = 5'd0; W_Data = 32'hFFFFFFFF; W_Be = 4'hF;
    Set_Busy = 1'b1; Busy_Addr = 5'd0; R_Addr_A = 5'd0; #1;
    chk("zero_bypass", R_Data_A, 32'h0);
    step();
    Write_Reg = 1'b0; Set_Busy = 1'b0; #1;
    chk("zero_data", R_Data_A, 32'h0);
    chk("zero_busy", {31'b0, Busy_A}, 32'h0);
    chk("nz_zero_data", nz_data_a, 32'hFFFFFFFF);
    chk("nz_zero_busy", {31'b0, nz_busy_a}, 32'h1);
    step();
    chk("zero_data_later", R_Data_A, 32'h0);
    // scoreboard
    Set_Busy = 1'b1; Busy_Addr = 5'd3; R_Addr_A = 5'd3;
    step();
    Set_Busy = 1'b0; #1;
    chk("sb_set", {31'b0, Busy_A}, 32'h1);
    Write_Reg = 1'b1; W_Addr = 5'd3; W_Data = 32'h33; W_Be = 4'hF; #1;
    chk("sb_bypass_busy", {31'b0, Busy_A}, 32'h0);
    chk("sb_nobypass_busy", {31'b0, nz_busy_a}, 32'h1);
    step();
    Write_Reg = 1'b0; #1;
    chk("sb_clear", {31'b0, Busy_A}, 32'h0);
    Write_Reg = 1'b1; Set_Busy = 1'b1;
    step();
    Write_Reg = 1'b0; Set_Busy = 1'b0; #1;
    chk("sb_set_wins", {31'b0, Busy_A}, 32'h1);
    chk("sb_set_wins_data", R_Data_A, 32'h33);
    // fill and clear
    for (int i = 0; i < 32; i++) begin
      Write_Reg = 1'b1; W_Addr = 5'(i); W_Data = 32'h01010101 * (i + 1); W_Be = 4'hF;
      Set_Busy = 1'b1; Busy_Addr = 5'(i);
      step();
    end
    Write_Reg = 1'b0; Set_Busy = 1'b0; R_Addr_A = 5'd31; R_Addr_B = 5'd30; #1;
    chk("fill_31", R_Data_A, 32'h20202020);
    chk("fill_busy_30", {31'b0, Busy_B}, 32'h1);
    Clear = 1'b1;
    step();
    Clear = 1'b0;
    Write_Reg = 1'b1; W_Addr = 5'd31; W_Data = 32'hCAFEF00D; W_Be = 4'hF;
    Set_Busy = 1'b1; Busy_Addr = 5'd31;
    n = 0;
    while (!Ready && n < 100) begin
      if (n == 5) begin
        Clear = 1'b1; #1;
        chk("mid_clear_read", R_Data_A, 32'h20202020);
        chk("mid_clear_no_bypass_busy", {31'b0, Busy_A}, 32'h1);
      end else Clear = 1'b0;
      n++;
      step();
    end
    Write_Reg = 1'b0; Set_Busy = 1'b0; Clear = 1'b0;
    chk("clear_ready_low_cycles", n, 32);
    for (int i = 0; i < 32; i++) begin
      R_Addr_A = 5'(i); R_Addr_B = 5'(i); #1;
      chk("cleared_data", R_Data_A, 32'h0);
      chk("cleared_busy", {31'b0, Busy_B}, 32'h0);
      chk("cleared_nz_data", nz_data_a, 32'h0);
    end
    // reset mid-clear
    Clear = 1'b1;
    step();
    Clear = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("clearing_ready", {31'b0, Ready}, 32'h0);
    Reset_n = 1'b0; #1;
    chk("reset_mid_clear_ready", {31'b0, Ready}, 32'h1);
    step();
    Reset_n = 1'b1;
    Write_Reg = 1'b1; W_Addr = 5'd20; W_Data = 32'h5A5A5A5A; W_Be = 4'hF;
    step();
    Write_Reg = 1'b0; R_Addr_A = 5'd20; #1;
    chk("post_reset_write", R_Data_A, 32'h5A5A5A5A);
    chk("post_reset_ready", {31'b0, Ready}, 32'h1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
